// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: owns the state register, steps an external
// combinational round datapath once per accepted round key, and reports the ciphertext.
module aes_round_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] plain_text,
    input  logic [0:127] round_key,
    input  logic         key_valid,
    input  logic [0:127] round_data,
    output logic [0:127] state_q,
    output logic         key_req,
    output logic [3:0]   key_round,
    output logic         final_round,
    output logic         busy,
    output logic         done,
    output logic [0:127] cipher_text
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    fsm_t         fsm_reg;
    logic [0:127] block_reg;
    logic [0:127] state_reg;
    logic [0:127] cipher_reg;
    logic [3:0]   round_reg;
    logic         key_req_reg;
    logic         final_reg;
    logic         busy_reg;
    logic         done_reg;
    logic         key_ack;
    logic [0:127] whitened;

    // A key is consumed only while it is being requested; stray key_valid is dropped.
    assign key_ack = key_req_reg & key_valid;

    // Initial AddRoundKey, one byte lane at a time.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_ark
            assign whitened[8*gi +: 8] = block_reg[8*gi +: 8] ^ round_key[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg     <= IDLE;
            block_reg   <= '0;
            state_reg   <= '0;
            cipher_reg  <= '0;
            round_reg   <= '0;
            key_req_reg <= 1'b0;
            final_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (fsm_reg)
                IDLE: begin
                    if (start) begin
                        block_reg   <= plain_text;
                        round_reg   <= 4'd0;
                        key_req_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        fsm_reg     <= LOAD;
                    end
                end
                LOAD: begin
                    if (key_ack) begin
                        state_reg <= whitened;
                        round_reg <= 4'd1;
                        fsm_reg   <= ROUND;
                    end
                end
                ROUND: begin
                    if (key_ack) begin
                        state_reg <= round_data;
                        if (round_reg == LAST_ROUND) begin
                            cipher_reg  <= round_data;
                            key_req_reg <= 1'b0;
                            final_reg   <= 1'b0;
                            done_reg    <= 1'b1;
                            fsm_reg     <= DONE;
                        end else begin
                            round_reg <= round_reg + 4'd1;
                            // Outputs are registered, so flag the last round one step early.
                            final_reg <= (round_reg == LAST_ROUND - 4'd1);
                        end
                    end
                end
                DONE: begin
                    busy_reg <= 1'b0;
                    fsm_reg  <= IDLE;
                end
                default: fsm_reg <= IDLE;
            endcase
        end
    end

    assign state_q     = state_reg;
    assign key_req     = key_req_reg;
    assign key_round   = round_reg;
    assign final_round = final_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign cipher_text = cipher_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES-128 key schedule and round model,
// randomized blocks and key stalls, cycle-by-cycle protocol and result checks.
module tb_aes_round_ctrl;

    typedef logic [0:10][0:127] rk_t;

    localparam logic [0:127] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [0:127] plain_text;
    logic [0:127] round_key;
    logic         key_valid;
    logic [0:127] round_data;
    logic [0:127] state_q;
    logic         key_req;
    logic [3:0]   key_round;
    logic         final_round;
    logic         busy;
    logic         done;
    logic [0:127] cipher_text;

    logic [7:0]   sbox [256];
    rk_t          cur_rk;
    logic [0:127] held_ct;
    int           stall_plan [11];
    int           n_pass = 0;
    int           n_total = 0;

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .plain_text  (plain_text),
        .round_key   (round_key),
        .key_valid   (key_valid),
        .round_data  (round_data),
        .state_q     (state_q),
        .key_req     (key_req),
        .key_round   (key_round),
        .final_round (final_round),
        .busy        (busy),
        .done        (done),
        .cipher_text (cipher_text)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic rk_t expand(input logic [0:127] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_t         rk;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [0:127] o;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[8*i +: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            if (!last) begin
                a[4*c]   = gmul(b[4*c], 8'h02) ^ gmul(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+1] = b[4*c] ^ gmul(b[4*c+1], 8'h02) ^ gmul(b[4*c+2], 8'h03) ^ b[4*c+3];
                a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(b[4*c+2], 8'h02) ^ gmul(b[4*c+3], 8'h03);
                a[4*c+3] = gmul(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(b[4*c+3], 8'h02);
            end else begin
                for (int r = 0; r < 4; r++) a[4*c+r] = b[4*c+r];
            end
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = a[i] ^ k[8*i +: 8];
        return o;
    endfunction

    function automatic logic [0:127] aes_encrypt(input logic [0:127] pt, input logic [0:127] key);
        rk_t          rk;
        logic [0:127] s;
        rk = expand(key);
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, rk[r], r == 10);
        return s;
    endfunction

    // Key-schedule unit answers combinationally; datapath is the golden round model.
    always_comb begin
        round_key = '0;
        if (key_round <= 4'd10) round_key = cur_rk[key_round];
        round_data = aes_round(state_q, round_key, final_round);
    end

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One encryption. abort_k >= 0 asserts rst (with start) while that key is pending.
    task automatic run_block(input string tag, input logic [0:127] pt, input logic [0:127] key,
                             input int abort_k, input bit extra_starts);
        logic [0:127] exp_ct;
        int           left [11];
        int           k;
        int           cyc;
        int           stalls;
        bit           fin;
        bit           w_done;
        exp_ct = aes_encrypt(pt, key);
        cur_rk = expand(key);
        for (int i = 0; i < 11; i++) left[i] = stall_plan[i];
        plain_text = pt;
        start = 1'b1;
        key_valid = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        plain_text = rand128();
        k = 0; cyc = 0; stalls = 0; fin = 1'b0; w_done = 1'b0;
        while (!fin) begin
            cyc++;
            if (k <= 10) begin
                check({tag, " busy"}, busy, 1'b1);
                check({tag, " key_req"}, key_req, 1'b1);
                check({tag, " key_round"}, key_round, k);
                check({tag, " final_round"}, final_round, k == 10);
                check({tag, " done_early"}, done, 1'b0);
                check({tag, " ct_held"}, cipher_text, held_ct);
                if (k == 1 && !w_done) begin
                    check({tag, " whiten"}, state_q, pt ^ cur_rk[0]);
                    w_done = 1'b1;
                end
                if (extra_starts) begin
                    start = (cyc == 3 || cyc == 7);
                    plain_text = rand128();
                end
                if (k == abort_k) begin
                    rst = 1'b1;
                    start = 1'b1;
                    key_valid = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    start = 1'b0;
                    check({tag, " abort_busy"}, busy, 1'b0);
                    check({tag, " abort_key_round"}, key_round, 0);
                    check({tag, " abort_ct"}, cipher_text, 0);
                    check({tag, " abort_state"}, state_q, 0);
                    check({tag, " abort_key_req"}, key_req, 1'b0);
                    check({tag, " abort_final"}, final_round, 1'b0);
                    held_ct = '0;
                    for (int i = 0; i < 4; i++) begin
                        check({tag, " abort_done"}, done, 1'b0);
                        key_valid = 1'($urandom);
                        @(posedge clk); #1;
                    end
                    check({tag, " abort_idle"}, busy, 1'b0);
                    $display("blk %s pt=%h aborted in round %0d", tag, pt, k);
                    fin = 1'b1;
                end else if (left[k] > 0) begin
                    key_valid = 1'b0;
                    left[k]--;
                    stalls++;
                end else begin
                    key_valid = 1'b1;
                    k++;
                end
            end else begin
                check({tag, " done"}, done, 1'b1);
                check({tag, " done_busy"}, busy, 1'b1);
                check({tag, " done_key_req"}, key_req, 1'b0);
                check({tag, " done_final"}, final_round, 1'b0);
                check({tag, " done_key_round"}, key_round, 10);
                check({tag, " cipher"}, cipher_text, exp_ct);
                check({tag, " state"}, state_q, exp_ct);
                check({tag, " latency"}, cyc, 12 + stalls);
                held_ct = exp_ct;
                start = extra_starts;
                plain_text = rand128();
                key_valid = 1'($urandom);
                @(posedge clk); #1;
                start = 1'b0;
                check({tag, " idle_busy"}, busy, 1'b0);
                check({tag, " done_pulse"}, done, 1'b0);
                check({tag, " idle_key_round"}, key_round, 10);
                check({tag, " idle_ct"}, cipher_text, held_ct);
                $display("blk %s pt=%h ct=%h latency=%0d stalls=%0d", tag, pt, cipher_text, cyc, stalls);
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                if (cyc > 100) begin
                    check({tag, " timeout"}, cyc, 12 + stalls);
                    fin = 1'b1;
                end
            end
        end
    endtask

    initial begin
        build_sbox();
        rst = 1'b1; start = 1'b1; key_valid = 1'b1;
        plain_text = FIPS_PT; held_ct = '0; cur_rk = '0;
        for (int i = 0; i < 11; i++) stall_plan[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst key_req", key_req, 1'b0);
        check("rst final", final_round, 1'b0);
        check("rst key_round", key_round, 0);
        check("rst state", state_q, 0);
        check("rst ct", cipher_text, 0);
        rst = 1'b0; start = 1'b0;

        check("model fips", aes_encrypt(FIPS_PT, FIPS_KEY), FIPS_CT);
        run_block("fips", FIPS_PT, FIPS_KEY, -1, 1'b0);
        check("fips ct", cipher_text, FIPS_CT);

        stall_plan[0] = 3; stall_plan[5] = 3; stall_plan[10] = 3;
        run_block("fips_stall", FIPS_PT, FIPS_KEY, -1, 1'b0);
        check("fips_stall ct", cipher_text, FIPS_CT);
        for (int i = 0; i < 11; i++) stall_plan[i] = 0;

        run_block("fips_restart", FIPS_PT, FIPS_KEY, -1, 1'b1);
        check("fips_restart ct", cipher_text, FIPS_CT);

        // Idle with random inputs but no start: nothing may move.
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'($urandom);
            plain_text = rand128();
            @(posedge clk); #1;
            check("idle busy", busy, 1'b0);
            check("idle key_req", key_req, 1'b0);
            check("idle key_round", key_round, 10);
            check("idle ct", cipher_text, FIPS_CT);
        end

        run_block("abort", rand128(), rand128(), 6, 1'b0);
        run_block("after_abort", FIPS_PT, FIPS_KEY, -1, 1'b0);
        check("after_abort ct", cipher_text, FIPS_CT);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 11; i++)
                stall_plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_block($sformatf("rand%0d", n), rand128(), rand128(), -1, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
